uart_apb_master: RTL and testbench

//  APB3 initiator for the UART subsystem. Turns a simple valid/ready request into a full APB3 transfer.

---
 rtl/uart_apb_master.sv | 159 +++++++++++++++
 tb/tb_uart_apb_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_master.sv
// APB3 initiator for the UART subsystem: converts a valid/ready request into an
// APB3 SETUP/ACCESS transfer and returns a one-cycle response with read data and error status.
module uart_apb_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
    input  logic                      i_req_write,
    output logic                      o_rsp_valid,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_error,
    output logic                      o_rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
    output logic                      o_apb_pwrite,
    output logic                      o_apb_psel,
    output logic                      o_apb_penable,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
    input  logic                      i_apb_pready,
    input  logic                      i_apb_pslverr
);

    // A zero timeout still needs a 1-bit counter so the logic stays well-formed.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_r,       state_s;
    logic [CNT_W-1:0]          wait_cnt_r,    wait_cnt_s;
    logic [APB_ADDR_WIDTH-1:0] paddr_r,       paddr_s;
    logic [APB_DATA_WIDTH-1:0] pwdata_r,      pwdata_s;
    logic                      pwrite_r,      pwrite_s;
    logic                      psel_r,        psel_s;
    logic                      penable_r,     penable_s;
    logic                      rsp_valid_r,   rsp_valid_s;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic                      rsp_error_r,   rsp_error_s;
    logic                      rsp_timeout_r, rsp_timeout_s;
    logic                      timeout_hit_s;

    assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (wait_cnt_r == TO_LAST);

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        pwrite_s      = pwrite_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_error_s   = rsp_error_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_s    = ST_SETUP;
                    paddr_s    = i_req_addr;
                    pwdata_s   = i_req_wdata;
                    pwrite_s   = i_req_write;
                    psel_s     = 1'b1;
                    penable_s  = 1'b0;
                    wait_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                // pready takes priority over an expiring timeout in the same cycle.
                if (i_apb_pready) begin
                    state_s       = ST_RESP;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = pwrite_r ? {APB_DATA_WIDTH{1'b0}} : i_apb_prdata;
                    rsp_error_s   = i_apb_pslverr;
                    rsp_timeout_s = 1'b0;
                end else if (timeout_hit_s) begin
                    state_s       = ST_RESP;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = {APB_DATA_WIDTH{1'b0}};
                    rsp_error_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_apb_pclk) begin
        if (!i_apb_presetn) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= {CNT_W{1'b0}};
            paddr_r       <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r      <= {APB_DATA_WIDTH{1'b0}};
            pwrite_r      <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {APB_DATA_WIDTH{1'b0}};
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            pwrite_r      <= pwrite_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_error_r   <= rsp_error_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign o_req_ready   = (state_r == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_rdata   = rsp_rdata_r;
    assign o_rsp_error   = rsp_error_r;
    assign o_rsp_timeout = rsp_timeout_r;
    assign o_apb_paddr   = paddr_r;
    assign o_apb_pwdata  = pwdata_r;
    assign o_apb_pwrite  = pwrite_r;
    assign o_apb_psel    = psel_r;
    assign o_apb_penable = penable_r;

endmodule

// File: tb/tb_uart_apb_master.sv
// Randomized bench for uart_apb_master: a transaction-timeline model predicts every
// output on every cycle, and directed transfers pin the model with literal values.
module tb_uart_apb_master;

    localparam int TO = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        write;
        logic        err;
        int          waits;
    } txn_t;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_write = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = 32'd0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    uart_apb_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_apb_pclk   (clk),
        .i_apb_presetn(presetn),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_write  (req_write),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_error  (rsp_error),
        .o_rsp_timeout(rsp_timeout),
        .o_apb_paddr  (paddr),
        .o_apb_pwdata (pwdata),
        .o_apb_pwrite (pwrite),
        .o_apb_psel   (psel),
        .o_apb_penable(penable),
        .i_apb_prdata (prdata),
        .i_apb_pready (pready),
        .i_apb_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    txn_t        pend[$];
    txn_t        cur;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          act = 1'b0;
    bit          no_gap = 1'b0;
    int          acc_a = 0;
    int          prev_a = 0;
    int          pen_cnt = 0;
    int          acc_cnt = 0;
    int          rst_hold = 3;
    bit          sel_seen = 1'b0;
    int          sel_lat = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    logic        last_to = 1'b0;
    logic [31:0] obs_rdata = 32'd0;
    logic        obs_err = 1'b0;
    logic        obs_to = 1'b0;
    int          obs_lat = 0;
    int          obs_pen = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h want=%0h", nm, cyc, got, exp);
        end
    endtask

    // Model: a transfer accepted at cycle a with w slave waits occupies the bus for
    // min(w+1, TO) ACCESS cycles after one SETUP cycle, then responds the next cycle.
    task automatic compare_cycle();
        int          n_acc;
        bit          in_sel, in_pen, is_rsp, busy, e_to, e_err;
        logic [31:0] e_rdata;
        cyc++;
        if (!presetn) begin
            chk("rst_psel", psel, 0);
            chk("rst_penable", penable, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_error", rsp_error, 0);
            chk("rst_timeout", rsp_timeout, 0);
            chk("rst_paddr", paddr, 0);
            chk("rst_pwdata", pwdata, 0);
            chk("rst_pwrite", pwrite, 0);
            chk("rst_ready", req_ready, 1);
            act = 1'b0;
            last_rdata = 32'd0;
            last_err = 1'b0;
            last_to = 1'b0;
        end else begin
            n_acc  = (cur.waits + 1 < TO) ? cur.waits + 1 : TO;
            in_sel = act && cyc >= acc_a + 1 && cyc <= acc_a + 1 + n_acc;
            in_pen = act && cyc >= acc_a + 2 && cyc <= acc_a + 1 + n_acc;
            is_rsp = act && cyc == acc_a + 2 + n_acc;
            busy   = act && cyc >= acc_a + 1 && cyc <= acc_a + 2 + n_acc;
            chk("req_ready", req_ready, !busy);
            chk("psel", psel, in_sel);
            chk("penable", penable, in_pen);
            chk("rsp_valid", rsp_valid, is_rsp);
            if (act && penable) pen_cnt++;
            if (act && psel && !sel_seen) begin
                sel_seen = 1'b1;
                sel_lat = cyc - acc_a;
            end
            if (in_sel) begin
                chk("paddr", paddr, cur.addr);
                chk("pwdata", pwdata, cur.wdata);
                chk("pwrite", pwrite, cur.write);
            end
            if (is_rsp) begin
                e_to    = (cur.waits >= TO);
                e_err   = e_to || cur.err;
                e_rdata = (e_to || cur.write) ? 32'd0 : cur.rdata;
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_error", rsp_error, e_err);
                chk("rsp_timeout", rsp_timeout, e_to);
                obs_rdata = rsp_rdata;
                obs_err = rsp_error;
                obs_to = rsp_timeout;
                obs_lat = cyc - acc_a;
                obs_pen = pen_cnt;
                last_rdata = e_rdata;
                last_err = e_err;
                last_to = e_to;
                act = 1'b0;
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, last_rdata);
                chk("rsp_error_hold", rsp_error, last_err);
                chk("rsp_timeout_hold", rsp_timeout, last_to);
            end
        end
    endtask

    // Drives reset, the slave response and the request port for the coming edge.
    task automatic drive();
        if (rst_hold > 0) begin
            presetn = 1'b0;
            rst_hold--;
        end else begin
            presetn = 1'b1;
        end
        if (presetn && act && psel && penable) begin
            pready  = (acc_cnt == cur.waits);
            prdata  = (pready && !cur.write) ? cur.rdata : $urandom;
            pslverr = pready ? cur.err : 1'($urandom);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
        if (presetn && pend.size() > 0 && (no_gap || $urandom_range(0, 3) != 0)) begin
            req_valid = 1'b1;
            req_addr  = pend[0].addr;
            req_wdata = pend[0].wdata;
            req_write = pend[0].write;
            if (req_ready) begin
                cur = pend.pop_front();
                prev_a = acc_a;
                acc_a = cyc;
                act = 1'b1;
                pen_cnt = 0;
                sel_seen = 1'b0;
            end
        end else begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_write = 1'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_cycle();
        @(negedge clk);
        drive();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input int waits, input logic [31:0] rd, input logic e);
        txn_t t;
        t.addr = a;
        t.wdata = wd;
        t.write = w;
        t.waits = waits;
        t.rdata = rd;
        t.err = e;
        pend.push_back(t);
    endtask

    task automatic run_all(input int budget);
        int n = 0;
        while ((pend.size() != 0 || act) && n < budget) begin
            step();
            n++;
        end
        chk("drain_bound_expired", n >= budget, 0);
        step();
    endtask

    initial begin
        repeat (5) step();

        // zero-wait write
        push(32'h4, 32'hA5A5_0001, 1'b1, 0, 32'h0, 1'b0);
        run_all(50);
        chk("t1_sel_lat", sel_lat, 1);
        chk("t1_rsp_lat", obs_lat, 3);
        chk("t1_error", obs_err, 0);
        chk("t1_rdata", obs_rdata, 0);

        // read with one wait state
        push(32'h0, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0);
        run_all(50);
        chk("t2_pen_cycles", obs_pen, 2);
        chk("t2_rdata", obs_rdata, 32'h1234_5678);
        chk("t2_error", obs_err, 0);

        // slave error
        push(32'h40, 32'hDEAD_BEEF, 1'b1, 0, 32'h0, 1'b1);
        run_all(50);
        chk("t3_error", obs_err, 1);
        chk("t3_timeout", obs_to, 0);

        // pready never rises
        push(32'h8, 32'h0, 1'b0, 99, 32'hCAFE_F00D, 1'b0);
        run_all(80);
        chk("t4_pen_cycles", obs_pen, 16);
        chk("t4_rsp_lat", obs_lat, 18);
        chk("t4_error", obs_err, 1);
        chk("t4_timeout", obs_to, 1);
        chk("t4_rdata", obs_rdata, 0);

        // pready on the last allowed ACCESS cycle beats the timeout
        push(32'hC, 32'h0, 1'b0, 15, 32'h0BAD_F00D, 1'b0);
        run_all(80);
        chk("tb_pen_cycles", obs_pen, 16);
        chk("tb_timeout", obs_to, 0);
        chk("tb_rdata", obs_rdata, 32'h0BAD_F00D);

        // two requests queued with valid held high
        no_gap = 1'b1;
        push(32'h10, 32'h1111_1111, 1'b1, 0, 32'h0, 1'b0);
        push(32'h14, 32'h0, 1'b0, 0, 32'h5555_AAAA, 1'b0);
        run_all(60);
        no_gap = 1'b0;
        chk("t5_accept_gap", acc_a - prev_a, 4);
        chk("t5_rdata", obs_rdata, 32'h5555_AAAA);

        // reset while in ACCESS
        push(32'h20, 32'h0, 1'b0, 99, 32'h0, 1'b0);
        begin
            int n = 0;
            while (!(act && penable) && n < 50) begin
                step();
                n++;
            end
            chk("t6_reach_access_bound", n >= 50, 0);
        end
        rst_hold = 1;
        repeat (4) step();
        push(32'h24, 32'h0, 1'b0, 2, 32'h7777_0000, 1'b0);
        run_all(50);
        chk("t6_after_rst_rdata", obs_rdata, 32'h7777_0000);
        chk("t6_after_rst_lat", obs_lat, 5);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 25) : $urandom_range(0, 4);
            push($urandom, $urandom, 1'($urandom), w, $urandom, 1'($urandom_range(0, 3) == 0));
        end
        run_all(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
